// File: rtl/display_scanout_if.sv
// Frame-buffer read port plus timed pixel stream of display_scanout.
// master = scanout side, slave = frame buffer / panel side.
interface display_scanout_if #(
    parameter int PX_PER_LINE = 330
);
    logic                     readFrame;
    logic [9:0]               readLineOutCounter;
    logic [0:PX_PER_LINE*8-1] FrameDataIn;
    logic [7:0]               PxOut;
    logic                     pxValid;
    logic                     hsync;
    logic                     vsync;
    logic [9:0]               PxCount;
    logic [9:0]               LineCount;

    modport master (
        output readFrame, readLineOutCounter, PxOut, pxValid, hsync, vsync, PxCount, LineCount,
        input  FrameDataIn
    );

    modport slave (
        input  readFrame, readLineOutCounter, PxOut, pxValid, hsync, vsync, PxCount, LineCount,
        output FrameDataIn
    );
endinterface

// File: rtl/display_scanout.sv
// Scans the frame buffer line by line and emits pixels with valid/hsync/vsync framing.
// Line period: REQ + LOAD + PX_PER_LINE active + H_BLANK blank; frame adds V_BLANK blank lines.
module display_scanout #(
    parameter int PX_PER_LINE = 330,
    parameter int LINES       = 110,
    parameter int LINE_BASE   = 10,
    parameter int H_BLANK     = 16,
    parameter int V_BLANK     = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    display_scanout_if.master bus,
    output logic [2:0]        stateDbg
);
    // No backpressure anywhere: readFrame is a one-cycle request and the buffer must present
    // FrameDataIn in the following (LOAD) cycle; pxValid qualifies PxOut and the panel cannot stall.
    localparam int LINE_PERIOD = PX_PER_LINE + H_BLANK + 2;
    localparam int CYC_W       = $clog2(LINE_PERIOD);
    localparam int VLN_W       = $clog2(V_BLANK + 1);
    localparam int H_W         = $clog2(H_BLANK + 1);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        REQ    = 3'd1,
        LOAD   = 3'd2,
        ACTIVE = 3'd3,
        HBLANK = 3'd4,
        VBLANK = 3'd5
    } state_t;

    state_t                   state, stateNxt;
    logic [0:PX_PER_LINE*8-1] lineReg;
    logic [9:0]               lineCount, lineCountNxt;
    logic [9:0]               pxCount, pxCountNxt;
    logic [9:0]               rloc, rlocNxt;
    logic [H_W-1:0]           hCnt, hCntNxt;
    logic [CYC_W-1:0]         vCnt, vCntNxt;
    logic [VLN_W-1:0]         vLine, vLineNxt;
    logic                     readFrame, readFrameNxt;
    logic                     pxValid, pxValidNxt;
    logic                     hsync, hsyncNxt;
    logic                     vsync, vsyncNxt;
    logic                     lastLine, vblankDone;
    int                       pxBase;

    assign lastLine   = (lineCount == 10'(LINES - 1));
    assign vblankDone = (vCnt == CYC_W'(LINE_PERIOD - 1)) && (vLine == VLN_W'(V_BLANK - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            lineReg   <= '0;
            lineCount <= '0;
            pxCount   <= '0;
            rloc      <= '0;
            hCnt      <= '0;
            vCnt      <= '0;
            vLine     <= '0;
            readFrame <= 1'b0;
            pxValid   <= 1'b0;
            hsync     <= 1'b0;
            vsync     <= 1'b0;
        end else begin
            state     <= stateNxt;
            lineCount <= lineCountNxt;
            pxCount   <= pxCountNxt;
            rloc      <= rlocNxt;
            hCnt      <= hCntNxt;
            vCnt      <= vCntNxt;
            vLine     <= vLineNxt;
            readFrame <= readFrameNxt;
            pxValid   <= pxValidNxt;
            hsync     <= hsyncNxt;
            vsync     <= vsyncNxt;
            if (state == LOAD) begin
                lineReg <= bus.FrameDataIn;
            end
        end
    end

    always_comb begin
        stateNxt = state;
        unique case (state)
            IDLE:    if (enable) stateNxt = REQ;
            REQ:     stateNxt = LOAD;
            LOAD:    stateNxt = ACTIVE;
            ACTIVE:  if (pxCount == 10'(PX_PER_LINE - 1)) stateNxt = HBLANK;
            HBLANK:  if (hCnt == H_W'(H_BLANK - 1)) stateNxt = lastLine ? VBLANK : REQ;
            VBLANK:  if (vblankDone) stateNxt = enable ? REQ : IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    // Registered outputs are decoded from the next state so they line up with the state they describe.
    always_comb begin
        lineCountNxt = lineCount;
        if (stateNxt == IDLE || (state == VBLANK && stateNxt != VBLANK)) begin
            lineCountNxt = '0;
        end else if (state == HBLANK && stateNxt == REQ) begin
            lineCountNxt = lineCount + 10'd1;
        end

        rlocNxt = rloc;
        if (stateNxt == REQ) begin
            rlocNxt = lineCountNxt + 10'(LINE_BASE);
        end else if (stateNxt == IDLE) begin
            rlocNxt = '0;
        end

        pxCountNxt = (state == ACTIVE && stateNxt == ACTIVE) ? pxCount + 10'd1 : '0;
        hCntNxt    = (state == HBLANK && stateNxt == HBLANK) ? hCnt + H_W'(1) : '0;

        vCntNxt  = '0;
        vLineNxt = '0;
        if (state == VBLANK && stateNxt == VBLANK) begin
            if (vCnt == CYC_W'(LINE_PERIOD - 1)) begin
                vLineNxt = vLine + VLN_W'(1);
            end else begin
                vCntNxt  = vCnt + CYC_W'(1);
                vLineNxt = vLine;
            end
        end

        readFrameNxt = (stateNxt == REQ);
        pxValidNxt   = (stateNxt == ACTIVE);
        vsyncNxt     = (stateNxt == VBLANK);
        // Blank lines keep the hsync phase of active lines: pulse in their last H_BLANK cycles.
        hsyncNxt     = (stateNxt == HBLANK) ||
                       (stateNxt == VBLANK && vCntNxt >= CYC_W'(LINE_PERIOD - H_BLANK));
    end

    always_comb begin
        pxBase = 8 * int'(pxCount);
    end

    assign bus.PxOut              = pxValid ? lineReg[pxBase +: 8] : 8'd0;
    assign bus.readFrame          = readFrame;
    assign bus.readLineOutCounter = rloc;
    assign bus.pxValid            = pxValid;
    assign bus.hsync              = hsync;
    assign bus.vsync              = vsync;
    assign bus.PxCount            = pxCount;
    assign bus.LineCount          = lineCount;
    assign stateDbg               = state;
endmodule

// File: tb/tb_display_scanout.sv
// Bench for display_scanout: directed vector table, then whole frames checked every cycle
// against a frame-time reference model and a pixel scoreboard fed by a frame-buffer model.
module tb_display_scanout;
    localparam int PX    = 330;
    localparam int LINES = 110;
    localparam int LB    = 10;
    localparam int HB    = 16;
    localparam int VB    = 4;
    localparam int LP    = PX + HB + 2;
    localparam int FRAME = (LINES + VB) * LP;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [2:0] stateDbg;

    display_scanout_if #(.PX_PER_LINE(PX)) bus();

    display_scanout #(
        .PX_PER_LINE(PX), .LINES(LINES), .LINE_BASE(LB), .H_BLANK(HB), .V_BLANK(VB)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable), .bus(bus), .stateDbg(stateDbg)
    );

    always #5 clk = ~clk;

    int         nVec = 0;
    int         nErr = 0;
    int         cyc = 0;
    bit         mRun = 1'b0;
    int         mT = 0;
    logic [7:0] exp_q[$];
    bit         prevRf = 1'b0;
    logic [9:0] servedIdx = '0;

    typedef struct packed {
        logic       rf;
        logic [9:0] rloc;
        logic       chkRloc;
        logic       pv;
        logic       hs;
        logic       vs;
        logic [9:0] line;
        logic [9:0] pxc;
        logic       chkPxc;
        logic       idle;
    } exp_t;

    typedef struct {
        logic       rst;
        logic       en;
        logic       rf;
        logic [9:0] rloc;
        logic       pv;
        logic [7:0] px;
        logic       idle;
    } vec_t;

    vec_t tbl[14];

    task automatic expect_eq(input string name, input logic [31:0] act, input logic [31:0] want);
        nVec++;
        if (act !== want) begin
            nErr++;
            $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Reference: the frame is a fixed timeline of LINES+V_BLANK lines of LP cycles each.
    task automatic model_step(input logic r, input logic e);
        if (r) begin
            mRun = 1'b0;
            mT   = 0;
            exp_q.delete();
        end else if (!mRun) begin
            if (e) begin
                mRun = 1'b1;
                mT   = 0;
            end
        end else begin
            mT++;
            if (mT == FRAME) begin
                mT = 0;
                if (!e) mRun = 1'b0;
            end
        end
        if (mRun && (mT % LP) == 1 && (mT / LP) < LINES) begin
            for (int k = 0; k < PX; k++) exp_q.push_back(8'(((mT / LP) + k) % 256));
        end
    endtask

    function automatic exp_t model_expect();
        exp_t e;
        int   line, c;
        e = '0;
        if (!mRun) begin
            e.chkRloc = 1'b1;
            e.chkPxc  = 1'b1;
            e.idle    = 1'b1;
        end else begin
            line = mT / LP;
            c    = mT % LP;
            if (line < LINES) begin
                e.line = 10'(line);
                e.rf   = (c == 0);
                if (e.rf) begin
                    e.chkRloc = 1'b1;
                    e.rloc    = 10'(line + LB);
                end
                e.pv = (c >= 2 && c < 2 + PX);
                if (e.pv) begin
                    e.pxc    = 10'(c - 2);
                    e.chkPxc = 1'b1;
                end
                e.hs = (c >= 2 + PX);
            end else begin
                e.line = 10'(LINES - 1);
                e.vs   = 1'b1;
                e.hs   = (c >= LP - HB);
            end
        end
        return e;
    endfunction

    task automatic check_cycle();
        exp_t        e;
        logic [7:0]  wantPx;
        logic [44:0] act, want, msk;
        bit          qErr;
        e      = model_expect();
        wantPx = 8'd0;
        qErr   = 1'b0;
        if (e.pv) begin
            if (exp_q.size() == 0) qErr = 1'b1;
            else wantPx = exp_q.pop_front();
        end
        act  = {bus.readFrame, bus.readLineOutCounter, bus.PxOut, bus.pxValid, bus.hsync, bus.vsync,
                bus.LineCount, bus.PxCount, stateDbg};
        want = {e.rf, e.rloc, wantPx, e.pv, e.hs, e.vs, e.line, e.pxc, 3'd0};
        msk  = {1'b1, {10{e.chkRloc}}, 8'hff, 3'b111, 10'h3ff, {10{e.chkPxc}}, {3{e.idle}}};
        nVec++;
        if (qErr || ((act & msk) !== (want & msk))) begin
            nErr++;
            $display("FAIL cycle %0d t=%0d: got rf=%0b idx=%0d px=%0d pv=%0b hs=%0b vs=%0b line=%0d pxc=%0d st=%0d; want rf=%0b idx=%0d px=%0d pv=%0b hs=%0b vs=%0b line=%0d pxc=%0d",
                     cyc, mT, bus.readFrame, bus.readLineOutCounter, bus.PxOut, bus.pxValid, bus.hsync,
                     bus.vsync, bus.LineCount, bus.PxCount, stateDbg, e.rf, e.rloc, wantPx, e.pv, e.hs,
                     e.vs, e.line, e.pxc);
        end
    endtask

    // Frame buffer: drives the requested line during LOAD, scribbles random bytes otherwise.
    task automatic serve_buffer();
        logic [0:PX*8-1] w;
        int              idx;
        w = bus.FrameDataIn;
        if (prevRf) begin
            for (int k = 0; k < PX; k++) w[8*k +: 8] = 8'((int'(servedIdx) - LB + k) % 256);
        end else begin
            for (int j = 0; j < 4; j++) begin
                idx = $urandom_range(0, PX - 1);
                w[8*idx +: 8] = 8'($urandom_range(0, 255));
            end
        end
        bus.FrameDataIn = w;
        prevRf    = bus.readFrame;
        servedIdx = bus.readLineOutCounter;
    endtask

    task automatic tick();
        logic r, e;
        r = reset;
        e = enable;
        @(posedge clk);
        cyc++;
        model_step(r, e);
        #1;
        check_cycle();
        serve_buffer();
    endtask

    // Runs one frame starting from its first REQ cycle (already observed).
    task automatic run_frame(input bit randomEn, input bit endEn);
        int rf, hs, vs, last;
        expect_eq("frame_start_req", {31'd0, bus.readFrame}, 1);
        expect_eq("frame_start_idx", bus.readLineOutCounter, LB);
        rf   = 1;
        hs   = 0;
        vs   = 0;
        last = cyc;
        for (int i = 1; i < FRAME; i++) begin
            if (randomEn) enable = 1'($urandom_range(0, 1));
            else enable = ((mT / LP) < 50);
            tick();
            if (bus.readFrame === 1'b1) begin
                rf++;
                expect_eq("line_period", cyc - last, LP);
                last = cyc;
            end
            hs += int'(bus.hsync === 1'b1);
            vs += int'(bus.vsync === 1'b1);
        end
        expect_eq("frame_line_reqs", rf, LINES);
        expect_eq("frame_hsync_cycles", hs, (LINES + VB) * HB);
        expect_eq("frame_vsync_cycles", vs, VB * LP);
        enable = endEn;
        tick();
        if (endEn) begin
            expect_eq("wrap_req", {31'd0, bus.readFrame}, 1);
            expect_eq("wrap_idx", bus.readLineOutCounter, LB);
            expect_eq("wrap_line", bus.LineCount, 0);
        end else begin
            expect_eq("stop_state_idle", stateDbg, 0);
            expect_eq("stop_no_req", {31'd0, bus.readFrame}, 0);
        end
    endtask

    initial begin
        #1_200_000;
        $display("FAIL watchdog: got timeout at cycle %0d, want completion", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr + 1);
        $fatal(1);
    end

    initial begin
        int guard;
        int rfIdle;

        //           rst en rf rloc pv px idle
        tbl[0]  = '{1, 1, 0, 0,  0, 0, 1};
        tbl[1]  = '{1, 1, 0, 0,  0, 0, 1};
        tbl[2]  = '{1, 1, 0, 0,  0, 0, 1};
        tbl[3]  = '{0, 1, 1, 10, 0, 0, 0};
        tbl[4]  = '{0, 0, 0, 0,  0, 0, 0};
        tbl[5]  = '{0, 0, 0, 0,  1, 0, 0};
        tbl[6]  = '{0, 1, 0, 0,  1, 1, 0};
        tbl[7]  = '{0, 0, 0, 0,  1, 2, 0};
        tbl[8]  = '{1, 1, 0, 0,  0, 0, 1};
        tbl[9]  = '{0, 0, 0, 0,  0, 0, 1};
        tbl[10] = '{0, 0, 0, 0,  0, 0, 1};
        tbl[11] = '{0, 1, 1, 10, 0, 0, 0};
        tbl[12] = '{0, 1, 0, 0,  0, 0, 0};
        tbl[13] = '{0, 1, 0, 0,  1, 0, 0};

        reset           = 1'b1;
        enable          = 1'b1;
        bus.FrameDataIn = '0;

        for (int i = 0; i < 14; i++) begin
            reset  = tbl[i].rst;
            enable = tbl[i].en;
            tick();
            nVec++;
            if (bus.readFrame !== tbl[i].rf || bus.pxValid !== tbl[i].pv || bus.PxOut !== tbl[i].px ||
                (tbl[i].rf && bus.readLineOutCounter !== tbl[i].rloc) ||
                (tbl[i].idle && (stateDbg !== 3'd0 || bus.LineCount !== 10'd0 || bus.PxCount !== 10'd0 ||
                                 bus.hsync !== 1'b0 || bus.vsync !== 1'b0 || bus.readLineOutCounter !== 10'd0))) begin
                nErr++;
                $display("FAIL table row %0d: got rf=%0b idx=%0d pv=%0b px=%0d st=%0d, want rf=%0b idx=%0d pv=%0b px=%0d idle=%0b",
                         i, bus.readFrame, bus.readLineOutCounter, bus.pxValid, bus.PxOut, stateDbg,
                         tbl[i].rf, tbl[i].rloc, tbl[i].pv, tbl[i].px, tbl[i].idle);
            end
        end

        // Reset in the middle of line 20, pixel 100.
        guard = 0;
        while (!(mRun && mT == 20 * LP + 2 + 100) && guard < 10000) begin
            enable = 1'($urandom_range(0, 1));
            tick();
            guard++;
        end
        expect_eq("reach_line20_px100", {31'd0, guard < 10000}, 1);
        expect_eq("midline_pxcount", bus.PxCount, 100);
        expect_eq("midline_linecount", bus.LineCount, 20);
        expect_eq("midline_px", bus.PxOut, (20 + 100) % 256);
        reset = 1'b1;
        tick();
        expect_eq("rst_pxvalid", {31'd0, bus.pxValid}, 0);
        expect_eq("rst_pxcount", bus.PxCount, 0);
        expect_eq("rst_linecount", bus.LineCount, 0);
        expect_eq("rst_state_idle", stateDbg, 0);
        reset  = 1'b0;
        enable = 1'b1;
        tick();

        // Full frame with enable toggling mid-frame, wrapping straight into the next frame.
        run_frame(1'b1, 1'b1);
        // Enable dropped at line 50: frame completes, then IDLE.
        run_frame(1'b0, 1'b0);

        rfIdle = 0;
        enable = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            rfIdle += int'(bus.readFrame !== 1'b0);
        end
        expect_eq("idle_no_req", rfIdle, 0);

        enable = 1'b1;
        tick();
        expect_eq("restart_req", {31'd0, bus.readFrame}, 1);
        expect_eq("restart_idx", bus.readLineOutCounter, LB);
        for (int i = 0; i < 2 * LP; i++) begin
            enable = 1'($urandom_range(0, 1));
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
        $finish;
    end
endmodule
